rf_write_sched: RTL and testbench
=================================

Name: rf_write_sched

Overview:
- Write-port scheduler and RAW scoreboard for the 16x16 register file in the 16-bit RISC CPU.
- Arbitrates the single register-file write port (RW/DA/D) between the ALU writeback and the memory-load writeback.
- Tracks outstanding writes per register so decode can stall on read-after-write hazards.
- Outputs drive the register file's write inputs directly; hazard/ready go to the decode/issue stage.

Parameters:
- AW, 4, register address width (2^AW registers)
- DW, 16, data width
- CW, 2, per-register outstanding-write counter width (max outstanding = 2^CW-1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_da  in  AW  ALU destination register
- alu_d  in  DW  ALU write data
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load writeback request
- mem_da  in  AW  load destination register
- mem_d  in  DW  load write data
- mem_ready  out  1  load request accepted this cycle
- rf_rw  out  1  register-file write enable (to RW)
- rf_da  out  AW  register-file write address (to DA)
- rf_d  out  DW  register-file write data (to D)
- issue_valid  in  1  decode issues an instruction that will write issue_da
- issue_da  in  AW  destination of issued instruction
- issue_ready  out  1  issue accepted (counter for issue_da not saturated)
- chk_aa  in  AW  source A of the instruction in decode
- chk_ba  in  AW  source B of the instruction in decode
- hazard  out  1  source A or B has an outstanding write
- pend  out  2^AW  per-register "count != 0" vector
- err  out  1  sticky: commit to a register with count 0

Behaviour:
- Reset (sync, highest priority): rf_rw=0, rf_da=0, rf_d=0, all counters=0, err=0, round-robin pointer = ALU-preferred. Reset asserted mid-operation drops any in-flight write: rf_rw=0 on the cycle after reset.
- Arbitration (combinational, same cycle):
  - Exactly one grant per cycle.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not granted last; pointer updates only on a contested or single grant.
  - Neither valid: no grant, pointer holds.
  - ready = grant; a requester holding valid waits at most 1 cycle.
  - Requester must hold valid/da/d stable until ready.
- Write port: registered, 1-cycle latency. Grant at cycle N gives rf_rw=1 with granted da/d during N+1, and the register file writes at the end of N+1. No grant gives rf_rw=0; rf_da/rf_d hold their last values.
- Scoreboard: one CW-bit counter per register.
  - inc: issue_valid & issue_ready on issue_da.
  - dec: rf_rw=1 on rf_da (commit).
  - inc and dec on the same register in the same cycle: count unchanged. Different registers: both apply.
  - issue_ready = (count[issue_da] != 2^CW-1). issue_valid with issue_ready=0 is ignored.
  - dec at count 0: count stays 0, err set (sticky until reset).
- pend[r] = (count[r] != 0), from registered state.
- hazard = pend[chk_aa] | pend[chk_ba], combinational from registered counts. It remains 1 during the commit cycle and drops the cycle after (conservative, no bypass).
- Register 0 is an ordinary writable register; no special casing.

Test Plan:
- Reset, then alu_valid=1 with da=3, d=0x1234 at cycle 0 -> alu_ready=1 at cycle 0; rf_rw=1, rf_da=3, rf_d=0x1234 at cycle 1; rf_rw=0 at cycle 2.
- alu_valid and mem_valid held high 4 cycles (alu da=1, mem da=2) -> grants in order ALU, MEM, ALU, MEM; rf_da sequence 1, 2, 1, 2, one per cycle.
- issue_valid da=5 three times -> pend[5]=1 and issue_ready=0 on the 4th attempt; chk_aa=5 -> hazard=1. Then three commits to r5 -> pend[5]=0 and hazard=0 the cycle after the 3rd commit.
- Same cycle: issue da=7 while a commit to r7 is active with count=1 -> count stays 1, pend[7]=1.
- Commit to r9 with count 0 (mem_valid da=9, no prior issue) -> err=1, count stays 0; err held until reset, cleared after reset.
- Reset asserted the cycle after a grant -> rf_rw=0 on the next cycle, all pend=0, err=0.

Source files
------------

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: round-robin ALU/load arbitration onto the
// single write port, plus per-register outstanding-write counters for RAW stalls.
module rf_write_sched #(
  parameter int AW = 4,
  parameter int DW = 16,
  parameter int CW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_da,
  input  logic [DW-1:0]    alu_d,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [AW-1:0]    mem_da,
  input  logic [DW-1:0]    mem_d,
  output logic             mem_ready,
  output logic             rf_rw,
  output logic [AW-1:0]    rf_da,
  output logic [DW-1:0]    rf_d,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_da,
  output logic             issue_ready,
  input  logic [AW-1:0]    chk_aa,
  input  logic [AW-1:0]    chk_ba,
  output logic             hazard,
  output logic [(1<<AW)-1:0] pend,
  output logic             err
);
  localparam int NR = 1 << AW;
  localparam logic [CW-1:0] CMAX = '1;

  logic          pref_mem;
  logic [CW-1:0] cnt [NR];
  logic          issue_fire;

  always_comb begin
    alu_ready  = alu_valid & (~mem_valid | ~pref_mem);
    mem_ready  = mem_valid & ~alu_ready;
    issue_ready = (cnt[issue_da] != CMAX);
    issue_fire = issue_valid & issue_ready;
    hazard     = pend[chk_aa] | pend[chk_ba];
  end

  // Pointer favours the loser of the last grant; it only moves when something is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_rw    <= 1'b0;
      rf_da    <= '0;
      rf_d     <= '0;
      pref_mem <= 1'b0;
      err      <= 1'b0;
    end else begin
      rf_rw <= alu_ready | mem_ready;
      if (alu_ready | mem_ready) begin
        pref_mem <= alu_ready;
        rf_da    <= alu_ready ? alu_da : mem_da;
        rf_d     <= alu_ready ? alu_d  : mem_d;
      end
      if (rf_rw && cnt[rf_da] == '0) err <= 1'b1;
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_cnt
    logic inc, dec;
    assign inc = issue_fire && (issue_da == AW'(r));
    assign dec = rf_rw && (rf_da == AW'(r));
    assign pend[r] = (cnt[r] != '0);

    always_ff @(posedge clk) begin
      if (reset)
        cnt[r] <= '0;
      else if (inc && !dec)
        cnt[r] <= cnt[r] + CW'(1);
      else if (dec && !inc && cnt[r] != '0)
        cnt[r] <= cnt[r] - CW'(1);
    end
  end
endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched: arbitration order, write latency,
// scoreboard saturation/hazard, same-cycle inc/dec, error flag and reset.
module tb_rf_write_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid;
  logic [3:0]  alu_da, mem_da, issue_da, chk_aa, chk_ba;
  logic [15:0] alu_d, mem_d;
  logic        alu_ready, mem_ready, rf_rw, issue_ready, hazard, err;
  logic [3:0]  rf_da;
  logic [15:0] rf_d;
  logic [15:0] pend;

  int n_chk = 0;
  int n_fail = 0;

  rf_write_sched #(.AW(4), .DW(16), .CW(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_da(alu_da), .alu_d(alu_d), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_da(mem_da), .mem_d(mem_d), .mem_ready(mem_ready),
    .rf_rw(rf_rw), .rf_da(rf_da), .rf_d(rf_d),
    .issue_valid(issue_valid), .issue_da(issue_da), .issue_ready(issue_ready),
    .chk_aa(chk_aa), .chk_ba(chk_ba), .hazard(hazard), .pend(pend), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0]  exp_da [4];
    logic [15:0] exp_d  [4];
    logic        exp_alu [4];
    exp_alu = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_da  = '{4'd1, 4'd2, 4'd1, 4'd2};
    exp_d   = '{16'h00a1, 16'h00b2, 16'h00a1, 16'h00b2};

    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_da = 0; mem_da = 0; issue_da = 0; chk_aa = 0; chk_ba = 0;
    alu_d = 0; mem_d = 0;
    do_reset();

    // reset state
    chk("rst_rf_rw", rf_rw, 0);
    chk("rst_rf_da", rf_da, 0);
    chk("rst_rf_d", rf_d, 0);
    chk("rst_pend", pend, 0);
    chk("rst_err", err, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_issue_ready", issue_ready, 1);

    // single ALU write, with a matching issue so the commit is legitimate
    alu_valid = 1; alu_da = 4'd3; alu_d = 16'h1234;
    issue_valid = 1; issue_da = 4'd3;
    #1;
    chk("s1_alu_ready", alu_ready, 1);
    chk("s1_mem_ready", mem_ready, 0);
    step();
    alu_valid = 0; issue_valid = 0;
    chk("s1_rf_rw_c1", rf_rw, 1);
    chk("s1_rf_da_c1", rf_da, 3);
    chk("s1_rf_d_c1", rf_d, 16'h1234);
    chk("s1_pend3_c1", pend[3], 1);
    step();
    chk("s1_rf_rw_c2", rf_rw, 0);
    chk("s1_rf_da_hold", rf_da, 3);
    chk("s1_pend3_c2", pend[3], 0);
    chk("s1_err", err, 0);

    // contested arbitration alternates starting with ALU
    do_reset();
    alu_valid = 1; alu_da = 4'd1; alu_d = 16'h00a1;
    mem_valid = 1; mem_da = 4'd2; mem_d = 16'h00b2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_alu_ready_%0d", i), alu_ready, exp_alu[i]);
      chk($sformatf("rr_mem_ready_%0d", i), mem_ready, !exp_alu[i]);
      step();
      if (i == 3) begin alu_valid = 0; mem_valid = 0; end
      chk($sformatf("rr_rf_rw_%0d", i), rf_rw, 1);
      chk($sformatf("rr_rf_da_%0d", i), rf_da, exp_da[i]);
      chk($sformatf("rr_rf_d_%0d", i), rf_d, exp_d[i]);
    end
    step();
    chk("rr_idle_rf_rw", rf_rw, 0);

    // saturate r5, then drain it with three load commits
    do_reset();
    issue_valid = 1; issue_da = 4'd5; chk_aa = 4'd5; chk_ba = 4'd0;
    #1;
    chk("sat_ready_0", issue_ready, 1);
    chk("sat_hazard_0", hazard, 0);
    step();
    step();
    step();
    chk("sat_ready_4th", issue_ready, 0);
    chk("sat_pend5", pend[5], 1);
    chk("sat_hazard", hazard, 1);
    step();
    issue_valid = 0;
    mem_valid = 1; mem_da = 4'd5; mem_d = 16'h5555;
    step();
    chk("drain_rf_rw", rf_rw, 1);
    step();
    step();
    mem_valid = 0;
    chk("drain_hazard_commit", hazard, 1);
    chk("drain_pend5_commit", pend[5], 1);
    step();
    chk("drain_pend5", pend[5], 0);
    chk("drain_hazard", hazard, 0);
    chk("drain_rf_rw_off", rf_rw, 0);
    chk("drain_err", err, 0);

    // issue and commit to r7 in the same cycle with count 1
    issue_valid = 1; issue_da = 4'd7;
    step();
    issue_valid = 0;
    mem_valid = 1; mem_da = 4'd7; mem_d = 16'h7777;
    step();
    mem_valid = 0;
    issue_valid = 1; issue_da = 4'd7; chk_aa = 4'd0; chk_ba = 4'd7;
    #1;
    chk("same_rf_rw", rf_rw, 1);
    chk("same_issue_ready", issue_ready, 1);
    step();
    issue_valid = 0;
    chk("same_pend7", pend[7], 1);
    chk("same_hazard", hazard, 1);
    chk("same_err", err, 0);
    chk("same_rf_rw_off", rf_rw, 0);
    step();
    chk("same_pend7_hold", pend[7], 1);

    // commit to r9 with nothing outstanding
    do_reset();
    mem_valid = 1; mem_da = 4'd9; mem_d = 16'h9999;
    step();
    mem_valid = 0;
    chk("err_rf_rw", rf_rw, 1);
    chk("err_not_yet", err, 0);
    step();
    chk("err_set", err, 1);
    chk("err_pend9", pend[9], 0);
    step();
    step();
    chk("err_sticky", err, 1);
    do_reset();
    chk("err_cleared", err, 0);

    // reset the cycle after a grant drops state and the write port
    issue_valid = 1; issue_da = 4'd6;
    step();
    step();
    issue_valid = 0;
    chk("rst2_pend6", pend[6], 1);
    alu_valid = 1; alu_da = 4'd4; alu_d = 16'h4444;
    step();
    alu_valid = 0;
    reset = 1;
    chk("rst2_rf_rw_pre", rf_rw, 1);
    step();
    reset = 0;
    chk("rst2_rf_rw", rf_rw, 0);
    chk("rst2_pend", pend, 0);
    chk("rst2_err", err, 0);

    // reset coincident with a grant also suppresses the write
    alu_valid = 1; alu_da = 4'd2; reset = 1;
    step();
    alu_valid = 0; reset = 0;
    chk("rst3_rf_rw", rf_rw, 0);
    chk("rst3_rf_da", rf_da, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
